// File: rtl/fetch_sequencer.sv
// Purpose : owns the PC and issues one word-addressed instruction fetch at a time, holding each returned word for decode.
// Latency : request one cycle after IDLE, instr_valid the cycle after imem_ack; min 3 cycles/instr with zero-latency ack.
// Backpr. : a held instruction stalls fetch until instr_ready or redirect; halt stops new fetches only from IDLE/HALT.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   imem_req/imem_addr            fetch request and word address (address stable until ack)
//   imem_ack/imem_rdata           memory response, ignored when no request is outstanding
//   instr_valid/instr/instr_pc    held instruction and its fetch address, valid/ready handshake
//   instr_ready                   decode accepts the held instruction
//   redirect/redirect_pc          one-cycle branch/jump pulse; squashes the held word or in-flight fetch
//   halt/halted                   level request to stop fetching / status while stopped
//   pc                            next fetch address
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              squash, squash_nxt;
    // Address of a fetch that was redirected while still awaiting its ack.
    // pc already holds the redirect target, but memory must keep seeing
    // the original address until the response arrives.
    logic [ADDR_W-1:0] inflight_addr, inflight_addr_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic [ADDR_W-1:0] instr_pc_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            squash        <= 1'b0;
            inflight_addr <= '0;
            instr         <= '0;
            instr_pc      <= '0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            squash        <= squash_nxt;
            inflight_addr <= inflight_addr_nxt;
            instr         <= instr_nxt;
            instr_pc      <= instr_pc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. redirect wins over ack capture and instr_ready.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc;
        squash_nxt        = squash;
        inflight_addr_nxt = inflight_addr;
        instr_nxt         = instr;
        instr_pc_nxt      = instr_pc;

        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end
                state_nxt = halt ? HALT : FETCH;
            end

            FETCH: begin
                if (imem_ack) begin
                    if (squash || redirect) begin
                        // Response belongs to a squashed fetch: drop it.
                        // pc already holds the target unless the redirect
                        // arrives together with the ack.
                        squash_nxt = 1'b0;
                        if (redirect) begin
                            pc_nxt = redirect_pc;
                        end
                        state_nxt = IDLE;
                    end else begin
                        instr_nxt    = imem_rdata;
                        instr_pc_nxt = pc;
                        pc_nxt       = pc + PC_STEP;
                        state_nxt    = HOLD;
                    end
                end else if (redirect) begin
                    pc_nxt     = redirect_pc;
                    squash_nxt = 1'b1;
                    // A second redirect before the ack must not overwrite
                    // the address still on the bus.
                    if (!squash) begin
                        inflight_addr_nxt = pc;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = IDLE;
                end else if (instr_ready) begin
                    state_nxt = IDLE;
                end
            end

            HALT: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end
                if (!halt) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_req    = (state == FETCH);
        imem_addr   = (state == FETCH && squash) ? inflight_addr : pc;
        instr_valid = (state == HOLD);
        halted      = (state == HALT);
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose : self-checking bench for fetch_sequencer: directed vector table, hand-written corner sequences, randomized run vs transaction model.
// Latency : inputs driven 1 time unit after posedge; outputs sampled after the edge or at negedge.
// Backpr. : random instr_ready, random ack latency 0..3 and stray acks while no request is outstanding.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .halted     (halted),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        halt;
        logic        redirect;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_halted;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic h, input logic rd, input logic [31:0] rpc,
                                input logic ak, input logic [31:0] rdata, input logic rdy,
                                input logic q, input logic [31:0] a, input logic v,
                                input logic [31:0] ins, input logic [31:0] ipc,
                                input logic hd, input logic [31:0] p);
        vec_t r;
        r.halt = h; r.redirect = rd; r.rpc = rpc; r.ack = ak; r.rdata = rdata; r.ready = rdy;
        r.e_req = q; r.e_addr = a; r.e_vld = v; r.e_instr = ins; r.e_ipc = ipc;
        r.e_halted = hd; r.e_pc = p;
        return r;
    endfunction

    // Instruction memory contents used by the randomized run.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference model for the randomized run
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_sq;
    logic [31:0] m_addr;
    logic        prev_halt;
    logic [31:0] exp_q[$];
    int          n_acc;

    task automatic model_step();
        chk("pc", pc, m_pc);
        if (m_out) chk("req_held", {31'd0, imem_req}, 32'd1);
        if (imem_req) begin
            if (!m_out) begin
                chk("req_addr", imem_addr, m_pc);
                chk("req_while_halt", {31'd0, prev_halt}, 32'd0);
                m_out  = 1'b1;
                m_addr = imem_addr;
            end else begin
                chk("addr_stable", imem_addr, m_addr);
            end
        end
        chk("valid", {31'd0, instr_valid}, {31'd0, (exp_q.size() != 0)});
        if (instr_valid && exp_q.size() != 0) begin
            chk("instr_pc", instr_pc, exp_q[0]);
            chk("instr", instr, mem_fn(exp_q[0]));
        end
        if (halted) begin
            chk("halted_needs_halt", {31'd0, prev_halt}, 32'd1);
            chk("halted_no_req", {31'd0, imem_req}, 32'd0);
        end

        // Events taking effect at the coming edge.
        if (instr_valid && exp_q.size() != 0 && (redirect || instr_ready)) begin
            void'(exp_q.pop_front());
            if (instr_ready) n_acc++;
        end
        if (redirect) begin
            if (m_out && imem_ack) begin
                m_out = 1'b0;
                m_sq  = 1'b0;
            end else if (m_out) begin
                m_sq = 1'b1;
            end
            m_pc = redirect_pc;
        end else if (m_out && imem_ack) begin
            m_out = 1'b0;
            if (m_sq) begin
                m_sq = 1'b0;
            end else begin
                exp_q.push_back(m_addr);
                m_pc = m_addr + 32'd1;
            end
        end
        prev_halt = halt;
    endtask

    initial begin
        logic [130:0] act_v;
        logic [130:0] exp_v;
        int           wait_cnt;
        int           lat;

        //               h  rd rpc        ak rdata         rdy | q  addr       v  instr         ipc        hd pc
        vecs[0]  = mk(0, 0, 32'h0,  0, 32'h0,    1,  1, 32'h0,  0, 32'h0,    32'h0,  0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,  0, 32'h0,    1,  1, 32'h0,  0, 32'h0,    32'h0,  0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,  1, 32'h1000, 1,  0, 32'h1,  1, 32'h1000, 32'h0,  0, 32'h1);
        vecs[3]  = mk(0, 0, 32'h0,  0, 32'h0,    0,  0, 32'h1,  1, 32'h1000, 32'h0,  0, 32'h1);
        vecs[4]  = mk(0, 0, 32'h0,  0, 32'h0,    1,  0, 32'h1,  0, 32'h1000, 32'h0,  0, 32'h1);
        vecs[5]  = mk(0, 0, 32'h0,  0, 32'h0,    1,  1, 32'h1,  0, 32'h1000, 32'h0,  0, 32'h1);
        vecs[6]  = mk(0, 0, 32'h0,  1, 32'h1001, 1,  0, 32'h2,  1, 32'h1001, 32'h1,  0, 32'h2);
        vecs[7]  = mk(0, 0, 32'h0,  0, 32'h0,    1,  0, 32'h2,  0, 32'h1001, 32'h1,  0, 32'h2);
        vecs[8]  = mk(0, 0, 32'h0,  0, 32'h0,    1,  1, 32'h2,  0, 32'h1001, 32'h1,  0, 32'h2);
        vecs[9]  = mk(0, 1, 32'h40, 0, 32'h0,    1,  1, 32'h2,  0, 32'h1001, 32'h1,  0, 32'h40);
        vecs[10] = mk(0, 0, 32'h0,  1, 32'hDEAD, 1,  0, 32'h40, 0, 32'h1001, 32'h1,  0, 32'h40);
        vecs[11] = mk(0, 0, 32'h0,  0, 32'h0,    1,  1, 32'h40, 0, 32'h1001, 32'h1,  0, 32'h40);
        vecs[12] = mk(0, 1, 32'h80, 1, 32'h2040, 1,  0, 32'h80, 0, 32'h1001, 32'h1,  0, 32'h80);
        vecs[13] = mk(1, 0, 32'h0,  0, 32'h0,    1,  0, 32'h80, 0, 32'h1001, 32'h1,  1, 32'h80);
        vecs[14] = mk(1, 1, 32'h10, 0, 32'h0,    1,  0, 32'h10, 0, 32'h1001, 32'h1,  1, 32'h10);
        vecs[15] = mk(0, 0, 32'h0,  0, 32'h0,    1,  0, 32'h10, 0, 32'h1001, 32'h1,  0, 32'h10);
        vecs[16] = mk(0, 0, 32'h0,  0, 32'h0,    1,  1, 32'h10, 0, 32'h1001, 32'h1,  0, 32'h10);
        vecs[17] = mk(0, 0, 32'h0,  1, 32'h3010, 1,  0, 32'h11, 1, 32'h3010, 32'h10, 0, 32'h11);
        vecs[18] = mk(0, 1, 32'h80, 0, 32'h0,    1,  0, 32'h80, 0, 32'h3010, 32'h10, 0, 32'h80);
        vecs[19] = mk(1, 0, 32'h0,  0, 32'h0,    1,  0, 32'h80, 0, 32'h3010, 32'h10, 1, 32'h80);
        vecs[20] = mk(0, 0, 32'h0,  0, 32'h0,    1,  0, 32'h80, 0, 32'h3010, 32'h10, 0, 32'h80);

        // ---------------- reset state ----------------
        drive_idle();
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        rst = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 21; i++) begin
            halt = vecs[i].halt; redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
            imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata; instr_ready = vecs[i].ready;
            cyc();
            act_v = {imem_req, imem_addr, instr_valid, instr, instr_pc, halted, pc};
            exp_v = {vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_instr,
                     vecs[i].e_ipc, vecs[i].e_halted, vecs[i].e_pc};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL vec%0d: got %h expected %h", i, act_v, exp_v);
            end
        end

        // ---------------- HOLD stall: 5 cycles without ready ----------------
        drive_idle();
        cyc();                                   // IDLE -> FETCH @0x80
        imem_ack = 1'b1; imem_rdata = 32'h4080;
        cyc();                                   // -> HOLD
        imem_ack = 1'b0; imem_rdata = 32'hBAD0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, 32'h4080);
            chk("stall_ipc", instr_pc, 32'h80);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        cyc();
        chk("stall_accept", {31'd0, instr_valid}, 32'd0);
        instr_ready = 1'b0;

        // ---------------- PC wrap ----------------
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cyc();                                   // IDLE -> FETCH @FFFFFFFF
        redirect = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFF);
        imem_ack = 1'b1; imem_rdata = 32'h77;
        cyc();
        imem_ack = 1'b0;
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFF);
        chk("wrap_pc", pc, 32'h0);
        instr_ready = 1'b1;
        cyc();                                   // -> IDLE
        instr_ready = 1'b0;
        cyc();                                   // -> FETCH @0
        chk("wrap_addr1", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h78;
        cyc();
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        cyc();                                   // FETCH @1

        // ---------------- async reset mid-FETCH ----------------
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_ipc", instr_pc, 32'd0);
        chk("arst_pc", pc, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hCAFE;  // late response
        cyc();
        rst = 1'b0;
        cyc();                                   // IDLE -> FETCH, stray ack ignored
        imem_ack = 1'b0;
        chk("arst_refetch_req", {31'd0, imem_req}, 32'd1);
        chk("arst_refetch_addr", imem_addr, 32'd0);
        chk("arst_late_ack", {31'd0, instr_valid}, 32'd0);
        cyc();
        chk("arst_late_instr", instr, 32'd0);

        // ---------------- randomized run vs model ----------------
        drive_idle();
        rst = 1'b1;
        cyc();
        cyc();
        m_pc = 32'h0; m_out = 1'b0; m_sq = 1'b0; m_addr = '0; prev_halt = 1'b0; n_acc = 0;
        exp_q.delete();
        wait_cnt = 0;
        lat = $urandom_range(0, 3);
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            redirect = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFFF - $urandom_range(0, 1);
            else
                redirect_pc = $urandom_range(0, 255);
            instr_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) halt = ~halt;
            if (imem_req) begin
                if (wait_cnt >= lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_fn(imem_addr);
                    wait_cnt   = 0;
                    lat        = $urandom_range(0, 3);
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    wait_cnt++;
                end
            end else begin
                imem_ack   = ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom;
            end
            #4;
            model_step();
            cyc();
        end
        chk("accept_count_nonzero", {31'd0, (n_acc > 50)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
